// File: rtl/data_break_arbiter_pkg.sv
// Shared constants and types for the data-break arbiter: CPU state codes
// for the break cycles and the arbiter's own state encoding.
package data_break_arbiter_pkg;

   // Mirrors the DB0/DB1 major-state codes of the CPU state machine.
   localparam logic [4:0] DB0 = 5'd16;
   localparam logic [4:0] DB1 = 5'd17;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      DBA_IDLE = 2'd0,
      DBA_REQ  = 2'd1,
      DBA_XFER = 2'd2,
      DBA_ACK  = 2'd3
   } dba_state_t;

endpackage

// File: rtl/data_break_arbiter_db_prio_pick.sv
// Combinational priority picker: fixed (lowest index wins) or round-robin
// (first requester at or after ptr, wrapping).
module db_prio_pick #(
   parameter int NCHAN = 4,
   parameter int RR    = 0
) (
   input  logic [NCHAN-1:0] req,
   input  logic [2:0]       ptr,
   output logic [2:0]       idx,
   output logic             any
);

   int               c;
   logic [NCHAN-1:0] sh;

   // Scan from the lowest-priority offset down so the highest-priority hit is kept last.
   always_comb begin
      idx = '0;
      any = 1'b0;
      c   = 0;
      sh  = '0;
      for (int k = NCHAN - 1; k >= 0; k--) begin
         c  = (RR != 0) ? (int'(ptr) + k) % NCHAN : k;
         sh = req >> c;
         if (sh[0]) begin
            idx = 3'(c);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_break_arbiter.sv
// Multi-channel data-break front end: arbitrates peripheral break requests
// and sequences one transfer through the CPU's DB0/DB1 break cycles.
module data_break_arbiter
   import data_break_arbiter_pkg::*;
#(
   parameter int NCHAN = 4,
   parameter int RR    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NCHAN-1:0]      ch_req,
   input  logic [NCHAN-1:0]      ch_to_dev,
   input  logic [NCHAN*15-1:0]   ch_addr,
   input  logic [NCHAN*12-1:0]   ch_wdata,
   input  logic [4:0]            sm_state,
   input  logic [11:0]           mem_rdata,
   output logic                  data_break,
   output logic                  to_disk,
   output logic [14:0]           db_addr,
   output logic [11:0]           db_wdata,
   output logic [NCHAN-1:0]      ch_ack,
   output logic [11:0]           ch_rdata,
   output logic [2:0]            grant,
   output logic                  busy,
   output dba_state_t            dbg_state
);

   dba_state_t       state_q, state_d;
   logic [2:0]       ptr;
   logic [2:0]       pick_idx;
   logic             pick_any;
   logic [14:0]      sel_addr;
   logic [11:0]      sel_wdata;
   logic             sel_dir;
   logic [NCHAN-1:0] grant_oh;
   logic             req_g;
   logic [2:0]       next_ptr;

   db_prio_pick #(.NCHAN(NCHAN), .RR(RR)) u_pick (
      .req (ch_req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign sel_addr  = 15'(ch_addr  >> (15 * int'(pick_idx)));
   assign sel_wdata = 12'(ch_wdata >> (12 * int'(pick_idx)));
   assign sel_dir   = 1'(ch_to_dev >> pick_idx);
   assign grant_oh  = NCHAN'(1) << grant;
   assign req_g     = |(ch_req & grant_oh);
   assign next_ptr  = (grant == 3'(NCHAN - 1)) ? 3'd0 : grant + 3'd1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         DBA_IDLE: if (pick_any) state_d = DBA_REQ;
         DBA_REQ: begin
            if (sm_state == DB0) state_d = DBA_XFER;
            else if (!req_g)     state_d = DBA_IDLE;
         end
         DBA_XFER: if (sm_state == DB1) state_d = DBA_ACK;
         DBA_ACK:  state_d = DBA_IDLE;
         default:  state_d = DBA_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= DBA_IDLE;
         to_disk  <= 1'b0;
         db_addr  <= '0;
         db_wdata <= '0;
         ch_rdata <= '0;
         grant    <= '0;
         ptr      <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DBA_IDLE && pick_any) begin
            grant    <= pick_idx;
            to_disk  <= sel_dir;
            db_addr  <= sel_addr;
            db_wdata <= sel_wdata;
         end
         if (state_q == DBA_XFER && sm_state == DB1 && to_disk)
            ch_rdata <= mem_rdata;
         if (state_q == DBA_ACK && RR != 0)
            ptr <= next_ptr;
      end
   end

   // Break request and ack are pure decodes of the registered state.
   assign data_break = (state_q == DBA_REQ) || (state_q == DBA_XFER);
   assign ch_ack     = (state_q == DBA_ACK) ? grant_oh : '0;
   assign busy       = (state_q != DBA_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_break_arbiter.sv
// Directed bench for data_break_arbiter: fixed-priority and round-robin
// instances driven from shared stimulus.
module tb_data_break_arbiter;
   import data_break_arbiter_pkg::*;

   localparam logic [4:0] S0 = 5'd0;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ch_req, ch_to_dev;
   logic [59:0] ch_addr;
   logic [47:0] ch_wdata;
   logic [4:0]  sm_state;
   logic [11:0] mem_rdata;

   logic        f_db, f_td, f_busy, r_db, r_td, r_busy;
   logic [14:0] f_addr, r_addr;
   logic [11:0] f_wd, r_wd, f_rd, r_rd;
   logic [3:0]  f_ack, r_ack;
   logic [2:0]  f_gnt, r_gnt;
   dba_state_t  f_st, r_st;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_break_arbiter #(.NCHAN(4), .RR(0)) u_fix (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_to_dev(ch_to_dev),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .sm_state(sm_state), .mem_rdata(mem_rdata),
      .data_break(f_db), .to_disk(f_td), .db_addr(f_addr), .db_wdata(f_wd),
      .ch_ack(f_ack), .ch_rdata(f_rd), .grant(f_gnt), .busy(f_busy), .dbg_state(f_st)
   );

   data_break_arbiter #(.NCHAN(4), .RR(1)) u_rr (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_to_dev(ch_to_dev),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .sm_state(sm_state), .mem_rdata(mem_rdata),
      .data_break(r_db), .to_disk(r_td), .db_addr(r_addr), .db_wdata(r_wd),
      .ch_ack(r_ack), .ch_rdata(r_rd), .grant(r_gnt), .busy(r_busy), .dbg_state(r_st)
   );

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  to_dev;
      logic [4:0]  sm;
      logic [11:0] rdat;
      logic        e_db;
      logic [3:0]  e_ack;
      logic [2:0]  e_gnt;
      logic        e_td;
      logic [14:0] e_addr;
      logic [11:0] e_wd;
      logic [11:0] e_rd;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [3:0] req, input logic [3:0] to_dev, input logic [4:0] sm,
                      input logic [11:0] rdat, input logic e_db, input logic [3:0] e_ack,
                      input logic [2:0] e_gnt, input logic e_td, input logic [14:0] e_addr,
                      input logic [11:0] e_wd, input logic [11:0] e_rd, input logic e_busy);
      vec_t v;
      v.req = req; v.to_dev = to_dev; v.sm = sm; v.rdat = rdat;
      v.e_db = e_db; v.e_ack = e_ack; v.e_gnt = e_gnt; v.e_td = e_td;
      v.e_addr = e_addr; v.e_wd = e_wd; v.e_rd = e_rd; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      ch_req    = '0;
      ch_to_dev = '0;
      sm_state  = S0;
      mem_rdata = '0;
      ch_addr   = {15'o33333, 15'o12345, 15'o11111, 15'o00100};
      ch_wdata  = {12'o3333, 12'o2222, 12'o1111, 12'o0707};

      // Scenario 1: ch2 read
      add(4'b0100, 4'b0100, S0,  12'o0,    1, 4'b0000, 2, 1, 15'o12345, 12'o2222, 12'o0,    1);
      add(4'b0100, 4'b0100, DB0, 12'o0,    1, 4'b0000, 2, 1, 15'o12345, 12'o2222, 12'o0,    1);
      add(4'b0100, 4'b0100, DB1, 12'o7402, 0, 4'b0100, 2, 1, 15'o12345, 12'o2222, 12'o7402, 1);
      add(4'b0100, 4'b0100, S0,  12'o0,    0, 4'b0000, 2, 1, 15'o12345, 12'o2222, 12'o7402, 0);
      add(4'b0000, 4'b0000, S0,  12'o0,    0, 4'b0000, 2, 1, 15'o12345, 12'o2222, 12'o7402, 0);
      // Scenario 2: ch1 and ch3 writes, fixed priority
      add(4'b1010, 4'b0000, S0,  12'o0,    1, 4'b0000, 1, 0, 15'o11111, 12'o1111, 12'o7402, 1);
      add(4'b1010, 4'b0000, DB0, 12'o0,    1, 4'b0000, 1, 0, 15'o11111, 12'o1111, 12'o7402, 1);
      add(4'b1010, 4'b0000, DB1, 12'o5555, 0, 4'b0010, 1, 0, 15'o11111, 12'o1111, 12'o7402, 1);
      add(4'b1010, 4'b0000, S0,  12'o0,    0, 4'b0000, 1, 0, 15'o11111, 12'o1111, 12'o7402, 0);
      add(4'b1000, 4'b0000, S0,  12'o0,    1, 4'b0000, 3, 0, 15'o33333, 12'o3333, 12'o7402, 1);
      add(4'b1000, 4'b0000, DB0, 12'o0,    1, 4'b0000, 3, 0, 15'o33333, 12'o3333, 12'o7402, 1);
      add(4'b1000, 4'b0000, DB1, 12'o6666, 0, 4'b1000, 3, 0, 15'o33333, 12'o3333, 12'o7402, 1);
      add(4'b1000, 4'b0000, S0,  12'o0,    0, 4'b0000, 3, 0, 15'o33333, 12'o3333, 12'o7402, 0);
      add(4'b0000, 4'b0000, S0,  12'o0,    0, 4'b0000, 3, 0, 15'o33333, 12'o3333, 12'o7402, 0);
      // Cancel in REQ
      add(4'b0001, 4'b0000, S0,  12'o0,    1, 4'b0000, 0, 0, 15'o00100, 12'o0707, 12'o7402, 1);
      add(4'b0000, 4'b0000, S0,  12'o0,    0, 4'b0000, 0, 0, 15'o00100, 12'o0707, 12'o7402, 0);
      // Drop during XFER still completes
      add(4'b0001, 4'b0000, S0,  12'o0,    1, 4'b0000, 0, 0, 15'o00100, 12'o0707, 12'o7402, 1);
      add(4'b0001, 4'b0000, DB0, 12'o0,    1, 4'b0000, 0, 0, 15'o00100, 12'o0707, 12'o7402, 1);
      add(4'b0000, 4'b0000, S0,  12'o0,    1, 4'b0000, 0, 0, 15'o00100, 12'o0707, 12'o7402, 1);
      add(4'b0000, 4'b0000, DB1, 12'o1234, 0, 4'b0001, 0, 0, 15'o00100, 12'o0707, 12'o7402, 1);
      add(4'b0000, 4'b0000, S0,  12'o0,    0, 4'b0000, 0, 0, 15'o00100, 12'o0707, 12'o7402, 0);

      step();
      step();
      chk("rst_db",    32'(f_db),   32'd0);
      chk("rst_ack",   32'(f_ack),  32'd0);
      chk("rst_gnt",   32'(f_gnt),  32'd0);
      chk("rst_busy",  32'(f_busy), 32'd0);
      chk("rst_addr",  32'(f_addr), 32'd0);
      chk("rst_rdata", 32'(f_rd),   32'd0);
      chk("rst_state", 32'(f_st),   32'(DBA_IDLE));
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         ch_req    = vecs[i].req;
         ch_to_dev = vecs[i].to_dev;
         sm_state  = vecs[i].sm;
         mem_rdata = vecs[i].rdat;
         step();
         chk($sformatf("v%0d_db", i),    32'(f_db),   32'(vecs[i].e_db));
         chk($sformatf("v%0d_ack", i),   32'(f_ack),  32'(vecs[i].e_ack));
         chk($sformatf("v%0d_busy", i),  32'(f_busy), 32'(vecs[i].e_busy));
         chk($sformatf("v%0d_rdata", i), 32'(f_rd),   32'(vecs[i].e_rd));
         if (vecs[i].e_busy) begin
            chk($sformatf("v%0d_gnt", i),   32'(f_gnt),  32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_td", i),    32'(f_td),   32'(vecs[i].e_td));
            chk($sformatf("v%0d_addr", i),  32'(f_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_wdata", i), 32'(f_wd),   32'(vecs[i].e_wd));
         end
      end

      // Round-robin with all four channels held: grants 0,1,2,3,0
      reset = 1'b1;
      ch_req = '0;
      sm_state = S0;
      step();
      reset = 1'b0;
      ch_req = 4'b1111;
      ch_to_dev = 4'b0000;
      for (int g = 0; g < 5; g++) begin
         logic [2:0] eg;
         eg = 3'(g % 4);
         sm_state = S0;
         step();
         chk($sformatf("rr%0d_gnt", g),  32'(r_gnt), 32'(eg));
         chk($sformatf("rr%0d_db", g),   32'(r_db),  32'd1);
         chk($sformatf("fx%0d_gnt", g),  32'(f_gnt), 32'd0);
         sm_state = DB0;
         step();
         sm_state = DB1;
         step();
         chk($sformatf("rr%0d_ack", g),  32'(r_ack), 32'(4'b0001 << eg));
         sm_state = S0;
         step();
         chk($sformatf("rr%0d_idle", g), 32'(r_busy), 32'd0);
      end

      // Reset during XFER, then pointer must restart at 0
      ch_req = 4'b0100;
      ch_to_dev = 4'b0100;
      sm_state = S0;
      step();
      sm_state = DB0;
      step();
      chk("pre_rst_xfer", 32'(r_st), 32'(DBA_XFER));
      reset = 1'b1;
      sm_state = DB1;
      mem_rdata = 12'o4321;
      step();
      chk("xrst_db",    32'(r_db),   32'd0);
      chk("xrst_ack",   32'(r_ack),  32'd0);
      chk("xrst_busy",  32'(r_busy), 32'd0);
      chk("xrst_gnt",   32'(r_gnt),  32'd0);
      chk("xrst_td",    32'(r_td),   32'd0);
      chk("xrst_addr",  32'(r_addr), 32'd0);
      chk("xrst_wdata", 32'(r_wd),   32'd0);
      chk("xrst_rdata", 32'(r_rd),   32'd0);
      reset = 1'b0;
      ch_req = 4'b1001;
      ch_to_dev = 4'b0000;
      sm_state = S0;
      mem_rdata = '0;
      step();
      chk("post_rst_gnt", 32'(r_gnt), 32'd0);
      chk("post_rst_db",  32'(r_db),  32'd1);
      sm_state = DB0;
      step();
      sm_state = DB1;
      step();
      chk("post_rst_ack", 32'(r_ack), 32'(4'b0001));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_break_arbiter.md
# data_break_arbiter

Multi-channel data-break front end for the PDP-8/E CPU. It collects single-cycle direct-memory-access requests from up to `NCHAN` peripherals and selects one, either by fixed or by round-robin priority. It drives the state machine's `data_break` and `to_disk` inputs and presents the granted channel's 15-bit extended address and write data. It returns memory read data and a one-cycle acknowledge to the winning channel. It replaces the single hard-wired `data_break` / `to_disk` pair with a parametrised, arbitrated set of channels.

## Interface
Parameters:
- `NCHAN`, 4 — number of break channels, 1..8.
- `RR`, 0 — 0: fixed priority (channel 0 highest); 1: round-robin.

Ports:
- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high reset.
- `ch_req` in NCHAN — per-channel break request, level; held until `ch_ack`.
- `ch_to_dev` in NCHAN — 1: memory→device (read); 0: device→memory (write).
- `ch_addr` in NCHAN*15 — per-channel address; channel i is bits [15i+14:15i], i.e. {field[2:0], addr[11:0]}.
- `ch_wdata` in NCHAN*12 — per-channel write data, same packing at 12 bits.
- `sm_state` in 5 — current state from the state machine.
- `mem_rdata` in 12 — memory read data, valid while `sm_state == DB1`.
- `data_break` out 1 — break request to the state machine.
- `to_disk` out 1 — direction for the granted transfer (copy of `ch_to_dev[grant]`).
- `db_addr` out 15 — granted address.
- `db_wdata` out 12 — granted write data.
- `ch_ack` out NCHAN — one-hot, one-cycle completion pulse.
- `ch_rdata` out 12 — read data for the last completed read transfer.
- `grant` out 3 — index of the latched winner.
- `busy` out 1 — high in every state except IDLE.

## Operation
- States: IDLE, REQ, XFER, ACK.
- **IDLE:** if any `ch_req` is high, pick a winner.
  - The winner's index, direction, address and write data are registered into `grant`, `to_disk`, `db_addr` and `db_wdata`.
  - `data_break` is set to 1 and the block moves to REQ.
- **REQ:** `data_break` stays 1.
  - If `sm_state == DB0`, go to XFER.
  - Otherwise, if `ch_req[grant]` has dropped, cancel: `data_break` goes to 0, go to IDLE, no ack is issued.
- **XFER:** when `sm_state == DB1` is sampled:
  - For a read (`to_disk == 1`), capture `mem_rdata` into `ch_rdata`.
  - Clear `data_break` and go to ACK.
  - Request changes are ignored once XFER is entered; the transfer always completes.
- **ACK:** `ch_ack[grant]` = 1 for exactly this cycle.
  - In round-robin mode, the priority pointer becomes `(grant+1) mod NCHAN`.
  - Go to IDLE.
- **Fixed priority:** the lowest requesting index wins.
- **Round-robin:** the first requesting index at or after the pointer wins, wrapping modulo NCHAN.
- `ch_rdata` holds its value until the next completed read; write transfers leave it unchanged.
- Latched `db_addr`, `db_wdata` and `to_disk` are stable from the grant until IDLE is re-entered. Requester changes after the grant have no effect.
- Reset values: state IDLE, `data_break`=0, `to_disk`=0, `db_addr`=0, `db_wdata`=0, `ch_ack`=0, `ch_rdata`=0, `grant`=0, `busy`=0, pointer=0.
- Reset mid-transfer: the block returns to IDLE on the next edge and no ack is issued. The CPU is reset in the same cycle.

## Timing
- Latency from `ch_req` rising (sampled in IDLE) to `data_break`=1: 1 clock.
- From `DB1` sampled to `ch_ack`: 1 clock. `ch_rdata` is valid in the ack cycle.
- Requesters must drop `ch_req` on the edge after `ch_ack`; IDLE samples requests no earlier than that edge.
- Minimum spacing between grants: one IDLE cycle.
- Simultaneous requests are resolved in the same IDLE cycle; losers simply remain pending.
- A request rising during REQ, XFER or ACK waits until the next IDLE.

## Structure
- The `DB0` and `DB1` state codes come from the shared `parameters.v`. Local arbiter state encodings go beside them as `DBA_IDLE`, `DBA_REQ`, `DBA_XFER` and `DBA_ACK`.
- One sub-module, `db_prio_pick`: combinational, takes `req[NCHAN]`, `ptr` and `RR`, returns a winner index and `any`. It is reused by later I/O arbiters.

## Test plan
- Ch2 request, read, addr 15'o12345 → `data_break` after 1 clk; `to_disk`=1; `db_addr`=15'o12345. With SM at DB1 and `mem_rdata`=12'o7402 → `ch_ack`=4'b0100 one cycle, `ch_rdata`=12'o7402.
- `RR`=0, ch1 and ch3 request together, writes with `ch_wdata` 12'o1111 and 12'o3333 → ch1 granted first (`db_wdata` 12'o1111), then ch3. `ch_rdata` unchanged.
- `RR`=1, all four channels held requesting → grants 0,1,2,3,0 in order; pointer wraps after ch3.
- Ch0 drops request in REQ before DB0 → `data_break` to 0 next clock, no ack, back to IDLE. Ch0 dropping in XFER → transfer completes and ack is issued.
- `reset` asserted in XFER → all outputs at reset values next clock, no ack. A request after reset release is granted normally, with pointer at 0.
